// File: rtl/rot_amt_sequencer.sv
// Timed rotation-amount sequencer: holds a loaded word and advances the downstream
// rotator's amount by a programmable step every TICK_DIV enabled cycles, modulo N.
module rot_amt_sequencer #(
  parameter int unsigned N        = 10,
  parameter int unsigned TICK_DIV = 5_000_000,
  localparam int unsigned AW      = $clog2(N),
  localparam int unsigned CW      = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic [N-1:0]  din,
  input  logic          en,
  input  logic [AW-1:0] step,
  output logic [N-1:0]  data_out,
  output logic [AW-1:0] amt_out,
  output logic          tick,
  output logic          wrap,
  output logic          busy
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [AW:0]   NW = (AW + 1)'(N);
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [AW-1:0] amt_q, amt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic [AW:0]   step_ext;
  logic [AW-1:0] step_eff;
  logic [AW:0]   sum;
  logic [AW-1:0] amt_nx;
  logic          sum_wraps;

  // step < 2^AW < 2N, so a single conditional subtract is an exact mod N.
  always_comb begin
    step_ext  = {1'b0, step};
    step_eff  = (step_ext >= NW) ? AW'(step_ext - NW) : step;
    sum       = {1'b0, amt_q} + {1'b0, step_eff};
    sum_wraps = (sum >= NW);
    amt_nx    = sum_wraps ? AW'(sum - NW) : AW'(sum);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
      end
      StRun: begin
        if (en) begin
          if (cnt_q == TC) begin
            cnt_d  = '0;
            amt_d  = amt_nx;
            tick_d = 1'b1;
            wrap_d = sum_wraps;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // load overrides any terminal-count step in the same cycle; clr overrides load.
    if (load) begin
      state_d = StRun;
      data_d  = din;
      amt_d   = '0;
      cnt_d   = '0;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
    end
    if (clr) begin
      state_d = StIdle;
      data_d  = '0;
      amt_d   = '0;
      cnt_d   = '0;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign data_out = data_q;
  assign amt_out  = amt_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign busy     = (state_q == StRun);

endmodule

// File: tb/tb_rot_amt_sequencer.sv
// Bench for rot_amt_sequencer: directed scenarios plus random traffic, checked every
// cycle against a model that counts enabled cycles and steps the amount modulo N.
module tb_rot_amt_sequencer;

  localparam int N  = 10;
  localparam int TD = 4;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clr = 1'b0;
  logic          load = 1'b0;
  logic [N-1:0]  din = '0;
  logic          en = 1'b0;
  logic [AW-1:0] step = '0;
  logic [N-1:0]  data_out;
  logic [AW-1:0] amt_out;
  logic          tick;
  logic          wrap;
  logic          busy;

  int tests = 0;
  int fails = 0;
  string phase = "reset";

  // Reference state: enabled-cycle count since load decides when a step is due.
  int m_run = 0, m_data = 0, m_amt = 0, m_encnt = 0, m_tick = 0, m_wrap = 0;

  rot_amt_sequencer #(.N(N), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .din(din), .en(en), .step(step),
    .data_out(data_out), .amt_out(amt_out), .tick(tick), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_out", int'(data_out), m_data);
    chk("amt_out", int'(amt_out), m_amt);
    chk("tick", int'(tick), m_tick);
    chk("wrap", int'(wrap), m_wrap);
    chk("busy", int'(busy), m_run);
    chk("amt_range", int'(amt_out < AW'(N)), 1);
  endtask

  task automatic model_reset();
    m_run = 0; m_data = 0; m_amt = 0; m_encnt = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input int c, input int l, input int e, input int s, input int d);
    m_tick = 0;
    m_wrap = 0;
    if (c != 0) begin
      model_reset();
    end else if (l != 0) begin
      m_run = 1; m_data = d; m_amt = 0; m_encnt = 0;
    end else if (m_run != 0 && e != 0) begin
      m_encnt++;
      if (m_encnt % TD == 0) begin
        m_tick = 1;
        m_wrap = (m_amt + s % N >= N) ? 1 : 0;
        m_amt  = (m_amt + s % N) % N;
      end
    end
  endtask

  task automatic cyc(input int c, input int l, input int e, input int s, input int d);
    clr  = c[0];
    load = l[0];
    en   = e[0];
    step = AW'(s);
    din  = N'(d);
    @(posedge clk);
    model_edge(c, l, e, s, d);
    #1;
    check_all();
  endtask

  initial begin
    int ticks, wraps;
    // Reset state
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    #2 reset = 1'b0;
    cyc(0, 0, 1, 1, 0);

    // Basic stepping: step=1, ten steps through 9->0
    phase = "basic";
    cyc(0, 1, 1, 1, 'h001);
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 1, 1, 0);
      if (i == 3) chk("first_tick", int'(tick), 1);
      wraps += int'(wrap);
    end
    chk("wrap_count", wraps, 1);

    // Step reduction: 13 acts as 3
    phase = "step13";
    cyc(0, 1, 1, 13, 'h001);
    for (int i = 0; i < 28; i++) cyc(0, 0, 1, 13, 0);
    chk("amt_after7", int'(amt_out), 1);

    // Pause mid-count
    phase = "pause";
    cyc(0, 1, 1, 2, 'h0F0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 2, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 2, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 2, 0);

    // Load on a terminal-count cycle, then clr+load together
    phase = "prio";
    cyc(0, 1, 1, 1, 'h155);
    while (m_encnt % TD != TD - 1) cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 'h2AA);
    chk("no_tick", int'(tick), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 'h3FF);
    chk("clr_busy", int'(busy), 0);

    // Asynchronous reset mid-count with amt=5
    phase = "areset";
    cyc(0, 1, 1, 5, 'h0AB);
    for (int i = 0; i < TD + 2; i++) cyc(0, 0, 1, 5, 0);
    chk("amt_pre", int'(amt_out), 5);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    reset = 1'b0;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 5, 0);
      ticks += int'(tick);
    end
    chk("no_tick_after_reset", ticks, 0);

    // Zero step
    phase = "zero";
    cyc(0, 1, 1, 0, 'h00F);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0, 0);

    // Random traffic
    phase = "random";
    cyc(0, 1, 1, 1, 'h3C3);
    for (int i = 0; i < 600; i++) begin
      int c, l, e;
      c = ($urandom_range(0, 99) < 2) ? 1 : 0;
      l = ($urandom_range(0, 99) < 4) ? 1 : 0;
      e = ($urandom_range(0, 99) < 80) ? 1 : 0;
      cyc(c, l, e, int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rot_amt_sequencer.md
# rot_amt_sequencer

Timed rotation-amount sequencer that sits directly upstream of the parametric right rotator. It holds a loaded N-bit word and steps the rotator's amount input by a programmable step every TICK_DIV clock cycles, wrapping modulo N. It produces rotating-pattern displays, for example LED chasers, on the board.

## Interface
- N, 10: word width; must match the downstream rotator; N >= 2.
- TICK_DIV, 5_000_000: clock cycles per rotation step; TICK_DIV >= 2.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear to IDLE.
- load  in  1  capture din and start running.
- din  in  N  word to be rotated.
- en  in  1  run enable; low pauses stepping.
- step  in  $clog2(N)  rotation increment per tick.
- data_out  out  N  held word; drives rotator `in`.
- amt_out  out  $clog2(N)  current rotation amount; drives rotator `amt`; always in 0..N-1.
- tick  out  1  one-cycle pulse; high in the cycle amt_out first shows a new value.
- wrap  out  1  one-cycle pulse coincident with tick when the amount wrapped past N-1.
- busy  out  1  high in RUN.

## Operation
- The FSM has 2 states: IDLE and RUN.
- IDLE:
  - amt_out holds and the tick counter holds at 0.
  - load moves the FSM to RUN.
- RUN:
  - When en=1, the counter cnt (width $clog2(TICK_DIV)) counts 0..TICK_DIV-1 and wraps.
  - When cnt==TICK_DIV-1, at that edge amt_out <= (amt_out + step_eff) mod N, tick <= 1, and wrap <= (amt_out + step_eff >= N).
  - When en=0, cnt and amt_out hold, and tick and wrap are 0.
- Step reduction:
  - step_eff = step >= N ? step - N : step. This is exact because step < 2^$clog2(N) < 2N.
  - step_eff = 0 still produces tick pulses, with amt_out unchanged and wrap=0.
- Sum width: the sum amt_out + step_eff uses $clog2(N)+1 bits. The result is amt + step_eff - N when the sum >= N, otherwise the sum.
- step is sampled only at the terminal-count edge. Changes between ticks have no other effect.
- load (any state, clr=0): data_out <= din, amt_out <= 0, cnt <= 0, tick <= 0, wrap <= 0, state <= RUN.
- clr: state <= IDLE, data_out <= 0, amt_out <= 0, cnt <= 0, tick <= 0, wrap <= 0.
- Priority: reset > clr > load > terminal-count step.
  - load at a terminal-count edge suppresses that step and tick.
- busy = (state == RUN).
- amt_out never leaves 0..N-1. The downstream rotator's result for amt >= N is not a true modulo rotate, so this guarantee is mandatory.

## Timing
- On reset: state IDLE, data_out 0, amt_out 0, cnt 0, tick 0, wrap 0, busy 0. Reset takes effect asynchronously mid-count and mid-run.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- data_out, amt_out=0 and busy=1 are valid in the cycle after the load edge.
- The first step appears TICK_DIV cycles after the load edge, provided en stays 1. Subsequent steps follow every TICK_DIV enabled cycles.
- Deasserting en for k cycles delays the next tick by exactly k cycles.
- tick and wrap are high for exactly one cycle per step.

## Test plan
- Basic stepping:
  - Stimulus: N=10, TICK_DIV=4, reset, load din=10'h001, step=1, en=1.
  - Required: amt_out steps 1,2,…,9,0 every 4 cycles; first tick 4 cycles after load; wrap only on the 9→0 step; data_out stays 10'h001.
- Step reduction and wrap:
  - Stimulus: step=13 (step_eff=3), amt starting at 0.
  - Required: amt sequence 3,6,9,2,5,8,1; wrap on 9→2 and 8→1 only; amt_out never exceeds 9.
- Pause:
  - Stimulus: en=0 for 7 cycles mid-count.
  - Required: cnt and amt_out frozen; next tick delayed by exactly 7 cycles; no tick or wrap while paused.
- Priorities:
  - Stimulus: load at the terminal-count cycle with din=10'h2AA.
  - Required: no tick; amt_out=0; data_out=10'h2AA.
  - Stimulus: clr and load asserted together.
  - Required: IDLE, busy=0, data_out=0.
- Asynchronous reset:
  - Stimulus: assert reset mid-count with amt_out=5.
  - Required: all outputs 0 immediately without a clock edge; no tick after release until a new load.
- Zero step:
  - Stimulus: step=0 with en=1.
  - Required: tick pulses every 4 cycles; amt_out constant; wrap=0.
